sm_bus_arbiter: RTL and testbench
=================================

Name: sm_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU data bus.
- Master 0 is the CPU load/store port; master 1 is a DMA or debug engine.
- The single slave is a synchronous data memory or peripheral mux with a fixed 1-cycle read latency.
- The block serialises accesses with a req/ack handshake, registers the slave-side command and returns registered read data.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- FIXED_PRIO, 0. 0 = round-robin between masters; 1 = master 0 always wins.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write enable (1 = write).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_ack  out  1  master 0 completion pulse.
- m0_rdata  out  DW  master 0 read data.
- m1_req  in  1  master 1 access request.
- m1_we  in  1  master 1 write enable.
- m1_addr  in  AW  master 1 address.
- m1_wdata  in  DW  master 1 write data.
- m1_ack  out  1  master 1 completion pulse.
- m1_rdata  out  DW  master 1 read data.
- s_en  out  1  slave access strobe.
- s_we  out  1  slave write enable.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_rdata  in  DW  slave read data, valid the cycle after s_en.
- busy  out  1  high whenever state != IDLE.
- gnt_id  out  1  master currently or last granted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - last_gnt=1, so master 0 wins the first tie.
  - m0_rdata and m1_rdata cleared to 0.
  - Reset asserted mid-transaction aborts it: no ack is issued and the slave strobe drops immediately.
- FSM states: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE.
- IDLE:
  - Sample m0_req and m1_req.
  - Neither set: stay in IDLE.
  - One set: grant that master.
  - Both set, FIXED_PRIO=1: grant master 0.
  - Both set, FIXED_PRIO=0: grant !last_gnt.
  - On grant: latch that master's we/addr/wdata into command registers, set gnt_id, go to ACCESS.
- ACCESS (1 cycle):
  - s_en=1; s_we, s_addr and s_wdata driven from the command registers.
  - s_en=0 in every other state.
  - s_we, s_addr and s_wdata hold their last value outside ACCESS.
- CAPTURE (1 cycle):
  - For a read, s_rdata is registered into the granted master's rdata at the end of this cycle.
  - For a write, rdata is unchanged.
  - The other master's rdata is never modified.
- ACK (1 cycle):
  - Granted master's ack=1 for exactly one cycle.
  - last_gnt<=gnt_id.
  - Go to IDLE.
- Latency: the request is sampled at edge E; ack is high in the 3rd cycle after E. Requests are serviced one at a time; peak throughput is one access per 4 cycles.
- Master handshake rules:
  - Hold req, we, addr and wdata stable from req assertion until ack is seen.
  - Drop req on the edge that ends the ack cycle, or keep it high to request a new access.
  - req is ignored in ACCESS, CAPTURE and ACK; it is only sampled in IDLE.
  - Changing addr/wdata after the grant has no effect, because the command is latched.
- Fairness: with FIXED_PRIO=0 and both masters permanently requesting, grants alternate 0,1,0,1.
- Starvation: with FIXED_PRIO=1, master 1 may starve. This is intended for CPU-priority builds.
- m0_ack and m1_ack are never high in the same cycle.
- busy is high in ACCESS, CAPTURE and ACK.

Test Plan:
- Reset, then m0 read of addr 0x10 with the slave returning 0xDEADBEEF one cycle after s_en:
  - s_en high exactly 1 cycle with s_addr=0x10, s_we=0.
  - m0_ack high 3 cycles after the req edge; m0_rdata=0xDEADBEEF.
  - m1_ack stays 0.
- m1 write of 0x55AA to addr 0x20:
  - s_en=1 with s_we=1, s_addr=0x20, s_wdata=0x55AA.
  - m1_ack one cycle pulse; m1_rdata stays at its previous value.
- Both masters requesting from reset with FIXED_PRIO=0, 4 accesses each held high:
  - gnt_id sequence 0,1,0,1; acks alternate.
  - Each ack lands 4 cycles after the previous one.
- Same stimulus with FIXED_PRIO=1:
  - All grants go to m0 while m0_req stays high.
  - m1 is granted in the first IDLE in which m0_req is low.
- rst_n pulsed low during CAPTURE of an m1 read:
  - s_en=0, busy=0, m1_ack never pulses, m1_rdata=0.
  - After release, the next m0 request is serviced normally.
- m0 changes m0_addr from 0x10 to 0x30 during ACCESS:
  - s_addr remains 0x10.
  - The data captured is the slave's response to 0x10.

Source files
------------

// File: rtl/sm_bus_arbiter.sv
// sm_bus_arbiter: two-master, one-slave data-bus arbiter.
//   Master 0 (CPU load/store) and master 1 (DMA/debug) each use a req/ack
//   handshake. One access is serviced at a time through a 4-state sequence
//   IDLE -> ACCESS -> CAPTURE -> ACK. The slave has a fixed 1-cycle read
//   latency; read data is registered into the granted master's rdata.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata       master X command inputs
//   mX_ack                     one-cycle completion pulse for master X
//   mX_rdata                   registered read data for master X
//   s_en/we/addr/wdata         registered slave command (s_en only in ACCESS)
//   s_rdata                    slave read data, valid the cycle after s_en
//   busy                       high in ACCESS, CAPTURE and ACK
//   gnt_id                     master currently or last granted
module sm_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          s_en,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t state;
  logic   last_gnt;
  logic   pick;

  // Winner among the masters requesting this cycle; only used in IDLE.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

  // The s_we/s_addr/s_wdata registers double as the latched command: they
  // are loaded at grant and only change at the next grant, so they present
  // the command during ACCESS and hold their value in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      busy     <= 1'b0;
      s_en     <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt_id  <= pick;
            s_we    <= pick ? m1_we    : m0_we;
            s_addr  <= pick ? m1_addr  : m0_addr;
            s_wdata <= pick ? m1_wdata : m0_wdata;
            s_en    <= 1'b1;
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          s_en  <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (!s_we) begin
            if (gnt_id) m1_rdata <= s_rdata;
            else        m0_rdata <= s_rdata;
          end
          if (gnt_id) m1_ack <= 1'b1;
          else        m0_ack <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          busy     <= 1'b0;
          last_gnt <= gnt_id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Self-checking bench for sm_bus_arbiter. Two instances run side by side:
// u[0] uses round-robin arbitration, u[1] fixed priority to master 0.
// A cycle-level reference model predicts grants, slave commands, ack times
// and read data; a monitor compares DUT outputs against queued predictions.
module tb_sm_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  task automatic check(input int g, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL fp%0d.%s: got %0h expected %0h (cycle %0d)", g, name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] seed_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  typedef struct {
    int          cyc;
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    int          m;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } ack_t;

  for (genvar g = 0; g < 2; g++) begin : u
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack0, ack1, s_en, s_we, busy, gnt_id;
    logic [31:0] rdata0, rdata1, s_addr, s_wdata;
    logic [31:0] s_rdata = '0;

    sm_bus_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(g)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0_req   (req[0]),
      .m0_we    (we[0]),
      .m0_addr  (addr[0]),
      .m0_wdata (wdata[0]),
      .m0_ack   (ack0),
      .m0_rdata (rdata0),
      .m1_req   (req[1]),
      .m1_we    (we[1]),
      .m1_addr  (addr[1]),
      .m1_wdata (wdata[1]),
      .m1_ack   (ack1),
      .m1_rdata (rdata1),
      .s_en     (s_en),
      .s_we     (s_we),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_rdata  (s_rdata),
      .busy     (busy),
      .gnt_id   (gnt_id)
    );

    // Slave: memory with 1-cycle read latency; junk on s_rdata otherwise.
    logic [31:0] smem [logic [31:0]];
    initial forever begin
      @(posedge clk);
      if (s_en && !s_we)
        s_rdata <= smem.exists(s_addr) ? smem[s_addr] : seed_val(s_addr);
      else
        s_rdata <= $urandom;
      if (s_en && s_we) smem[s_addr] = s_wdata;
    end

    // Reference model: decides at mid-cycle what the arbiter will do at the
    // next edge, using the request inputs as they stand during IDLE.
    cmd_t        cmd_q[$];
    ack_t        ack_q[$];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    int          busy_left = 0;
    int          last      = 1;
    int          busy_from = 1;
    int          busy_to   = 0;
    int          win;

    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_left = 0;
        last      = 1;
        cmd_q.delete();
        ack_q.delete();
        exp_rd    = '{32'h0, 32'h0};
        busy_from = 1;
        busy_to   = 0;
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (req[0] || req[1]) begin
        if (req[0] && req[1]) win = (g == 1) ? 0 : 1 - last;
        else                  win = req[1] ? 1 : 0;
        last = win;
        if (we[win]) rmem[addr[win]] = wdata[win];
        else exp_rd[win] = rmem.exists(addr[win]) ? rmem[addr[win]] : seed_val(addr[win]);
        cmd_q.push_back('{cyc + 1, win, we[win], addr[win], wdata[win]});
        ack_q.push_back('{cyc + 3, win, exp_rd[0], exp_rd[1]});
        busy_from = cyc + 1;
        busy_to   = cyc + 3;
        busy_left = 3;
      end
    end

    // Monitor
    bit   logging = 0;
    int   gnt_log[$];
    int   ack_log[$];
    cmd_t ce;
    ack_t ae;
    initial forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check(g, "busy", busy, (cyc >= busy_from && cyc <= busy_to));
        if (ack0 && ack1) check(g, "ack_overlap", {ack0, ack1}, 2'b00);
        if (s_en) begin
          if (logging) gnt_log.push_back(int'(gnt_id));
          if (cmd_q.size() == 0) check(g, "s_en_spurious", s_en, 0);
          else begin
            ce = cmd_q.pop_front();
            check(g, "s_en_cycle", cyc, ce.cyc);
            check(g, "gnt_id", gnt_id, ce.m);
            check(g, "s_we", s_we, ce.we);
            check(g, "s_addr", s_addr, ce.addr);
            check(g, "s_wdata", s_wdata, ce.wdata);
          end
        end
        if (ack0 || ack1) begin
          if (logging) ack_log.push_back(cyc);
          if (ack_q.size() == 0) check(g, "ack_spurious", {ack0, ack1}, 0);
          else begin
            ae = ack_q.pop_front();
            check(g, "ack_cycle", cyc, ae.cyc);
            check(g, "ack_master", ack1 ? 1 : 0, ae.m);
            check(g, "m0_rdata", rdata0, ae.rd0);
            check(g, "m1_rdata", rdata1, ae.rd1);
          end
        end
      end
    end

    function automatic logic ack_of(input int m);
      return (m == 1) ? ack1 : ack0;
    endfunction

    task automatic txn(input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit keep);
      req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
      for (int t = 0; t < 40; t++) begin
        @(posedge clk);
        #1;
        if (ack_of(m)) begin
          if (!keep) req[m] = 1'b0;
          return;
        end
      end
      check(g, "ack_timeout", 0, 1);
      req[m] = 1'b0;
    endtask

    task automatic new_cmd(input int m);
      req[m]   = 1'b1;
      we[m]    = 1'($urandom_range(0, 1));
      addr[m]  = 32'($urandom_range(0, 7)) << 4;
      wdata[m] = $urandom;
    endtask

    // Random master; addr/wdata may be scrambled while waiting, which the
    // arbiter only honours up to the cycle it grants.
    task automatic rand_master(input int m, input int ncyc);
      int guard = 0;
      for (int k = 0; k < ncyc || (req[m] && guard < 200); k++) begin
        @(posedge clk);
        #1;
        if (k >= ncyc) guard++;
        if (req[m] && ack_of(m)) begin
          if (k < ncyc && $urandom_range(0, 1) == 1) new_cmd(m);
          else req[m] = 1'b0;
        end else if (!req[m]) begin
          if (k < ncyc && $urandom_range(0, 2) == 0) new_cmd(m);
        end else if ($urandom_range(0, 3) == 0) begin
          addr[m]  = 32'($urandom_range(0, 7)) << 4;
          wdata[m] = $urandom;
        end
      end
      check(g, "drain", req[m], 0);
      req[m] = 1'b0;
    endtask

    initial begin
      logic exp_g;
      int   ts;
      smem[32'h10] = 32'hDEADBEEF;
      rmem[32'h10] = 32'hDEADBEEF;
      rst_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
        req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
      end
      #1 rst_n = 1'b0;
      #1;
      check(g, "rst_s_en", s_en, 0);
      check(g, "rst_busy", busy, 0);
      check(g, "rst_gnt_id", gnt_id, 0);
      check(g, "rst_acks", {ack0, ack1}, 0);
      check(g, "rst_rdata", {rdata0, rdata1}, 0);
      check(g, "rst_s_cmd", {s_we, s_addr, s_wdata}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // m0 read of 0x10, m1 write of 0x55AA to 0x20
      txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
      check(g, "m0_read_data", rdata0, 32'hDEADBEEF);
      txn(1, 1'b1, 32'h20, 32'h55AA, 1'b0);
      check(g, "m1_rdata_after_write", rdata1, 0);

      // Both masters holding req high for 4 accesses each
      logging = 1;
      fork
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 32'h30 + 32'(i), 32'h0, i < 3);
        for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'h50 + 32'(i), 32'(i + 1), i < 3);
      join
      logging = 0;
      check(g, "order_len", gnt_log.size(), 8);
      for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
        exp_g = (g == 0) ? 1'(i % 2) : 1'(i >= 4);
        check(g, "order", gnt_log[i], exp_g);
      end
      for (int i = 1; i < ack_log.size(); i++)
        check(g, "ack_spacing", ack_log[i] - ack_log[i-1], 4);

      fork
        rand_master(0, 400);
        rand_master(1, 400);
      join
      repeat (6) @(posedge clk);

      // Reset during CAPTURE of an m1 read
      #1;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; wdata[1] = 32'h0;
      ts = 0;
      while (ts < 20 && !s_en) begin
        @(posedge clk);
        #1;
        ts++;
      end
      check(g, "reset_test_s_en_seen", s_en, 1);
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      req[1] = 1'b0;
      #1;
      check(g, "abort_s_en", s_en, 0);
      check(g, "abort_busy", busy, 0);
      check(g, "abort_m1_rdata", rdata1, 0);
      check(g, "abort_m0_rdata", rdata0, 0);
      for (int i = 0; i < 2; i++) begin
        @(posedge clk);
        #1;
        check(g, "abort_no_ack", {ack0, ack1}, 0);
      end
      rst_n = 1'b1;
      txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
      repeat (6) @(posedge clk);
      check(g, "cmd_q_empty", cmd_q.size(), 0);
      check(g, "ack_q_empty", ack_q.size(), 0);
      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && done_cnt < 2; t++) @(posedge clk);
    check(2, "global_timeout", done_cnt, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
